// File: rtl/norm_block_scheduler_pkg.sv
// Shared constants and types for the block scheduler and the binarized normalization unit.
// The NORM_PERF_CNT_EN macro (top module) adds frame-local performance counters.
package norm_block_scheduler_pkg;
   localparam int BIN_WIDTH       = 14;
   localparam int BINS            = 9;
   localparam int CELLS_PER_BLOCK = 4;
   localparam int CELLS_X         = 80;
   localparam int CELLS_Y         = 60;
   localparam int CELL_W          = BIN_WIDTH * (BINS + 1);
   localparam int IN_W            = CELL_W * CELLS_PER_BLOCK;
   localparam int OUT_W           = BINS * CELLS_PER_BLOCK;
   localparam int BX_W            = 7;
   localparam int BY_W            = 6;
   localparam int SUM_W           = 16;

   typedef struct packed {
      logic [BX_W-1:0] bx;
      logic [BY_W-1:0] by;
   } block_pos_t;

   // Bin i of cell j; i == BINS selects the cell sum.
   function automatic logic [BIN_WIDTH-1:0] cell_bin(input logic [IN_W-1:0] blk, input int j, input int i);
      return blk[(j * (BINS + 1) + i) * BIN_WIDTH +: BIN_WIDTH];
   endfunction
endpackage

// File: rtl/norm_block_scheduler_if.sv
// Candidate input / descriptor output bundle of the block scheduler.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; the source holds payload stable while valid && !ready.
interface norm_block_scheduler_if
   import norm_block_scheduler_pkg::*;
();
   logic             frame_start;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_block;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_desc;
   logic [BX_W-1:0]  out_bx;
   logic [BY_W-1:0]  out_by;
   logic             frame_done;

   modport slave (
      input  frame_start, in_valid, in_block, out_ready,
      output in_ready, out_valid, out_desc, out_bx, out_by, frame_done
   );

   modport master (
      output frame_start, in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_desc, out_bx, out_by, frame_done
   );
endinterface

// File: rtl/norm_block_scheduler_normalization.sv
// Binarized block normalization: bin >= (sum of the four cell sums) >> 4, combinational.
module normalization
   import norm_block_scheduler_pkg::*;
(
   input  logic             in_valid,
   input  logic             k_border,
   input  logic [IN_W-1:0]  block,
   output logic             out_valid,
   output logic [OUT_W-1:0] desc
);
   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] thr;

   assign out_valid = in_valid && !k_border;

   always_comb begin
      sum = '0;
      for (int j = 0; j < CELLS_PER_BLOCK; j++) begin
         sum = sum + SUM_W'(cell_bin(block, j, BINS));
      end
      thr  = sum >> 4;
      desc = '0;
      for (int j = 0; j < CELLS_PER_BLOCK; j++) begin
         for (int i = 0; i < BINS; i++) begin
            desc[i + j * BINS] = in_valid && (SUM_W'(cell_bin(block, j, i)) >= thr);
         end
      end
   end
endmodule

// File: rtl/norm_block_scheduler.sv
// Block scheduler: row-major position tracking, border drop, two-stage registered normalization.
// Optional NORM_PERF_CNT_EN adds perf_blocks / perf_stalls counters.
module norm_block_scheduler
   import norm_block_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   norm_block_scheduler_if.slave bus
`ifdef NORM_PERF_CNT_EN
   ,
   output logic [15:0] perf_blocks,
   output logic [15:0] perf_stalls
`endif
);
   logic             s1_valid;
   logic             s1_kb;
   logic [IN_W-1:0]  s1_block;
   block_pos_t       s1_pos;
   logic             s2_valid;
   logic [OUT_W-1:0] s2_desc;
   block_pos_t       s2_pos;
   logic [BX_W-1:0]  col;
   logic [BY_W-1:0]  row;
   logic             norm_valid;
   logic [OUT_W-1:0] norm_desc;
   logic             s2_free;
   logic             s1_retire;
   logic             accept;
   logic             out_fire;

   normalization u_norm (
      .in_valid  (s1_valid),
      .k_border  (s1_kb),
      .block     (s1_block),
      .out_valid (norm_valid),
      .desc      (norm_desc)
   );

   // A border candidate leaves S1 even when S2 is stalled, since it never needs S2.
   assign s2_free   = !s2_valid || bus.out_ready;
   assign s1_retire = s1_valid && (s1_kb || s2_free);
   assign bus.in_ready = !bus.frame_start && (!s1_valid || s1_retire);
   assign accept    = bus.in_valid && bus.in_ready;
   assign out_fire  = s2_valid && bus.out_ready;

   assign bus.out_valid  = s2_valid;
   assign bus.out_desc   = s2_desc;
   assign bus.out_bx     = s2_pos.bx;
   assign bus.out_by     = s2_pos.by;
   assign bus.frame_done = out_fire && (s2_pos.bx == BX_W'(CELLS_X - 2)) && (s2_pos.by == BY_W'(CELLS_Y - 2));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_kb    <= 1'b0;
         s1_pos   <= '0;
         s2_valid <= 1'b0;
         s2_desc  <= '0;
         s2_pos   <= '0;
         col      <= '0;
         row      <= '0;
      end else if (bus.frame_start) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         col      <= '0;
         row      <= '0;
      end else begin
         if (s2_free) begin
            s2_valid <= norm_valid;
            if (norm_valid) begin
               s2_desc <= norm_desc;
               s2_pos  <= s1_pos;
            end
         end
         if (accept) begin
            s1_valid <= 1'b1;
            s1_block <= bus.in_block;
            s1_pos   <= '{bx: col, by: row};
            s1_kb    <= (col == BX_W'(CELLS_X - 1));
            if (col == BX_W'(CELLS_X - 1)) begin
               col <= '0;
               row <= (row == BY_W'(CELLS_Y - 2)) ? '0 : row + BY_W'(1);
            end else begin
               col <= col + BX_W'(1);
            end
         end else if (s1_retire) begin
            s1_valid <= 1'b0;
         end
      end
   end

`ifdef NORM_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || bus.frame_start) begin
         perf_blocks <= '0;
         perf_stalls <= '0;
      end else begin
         if (out_fire && perf_blocks != 16'hFFFF) perf_blocks <= perf_blocks + 16'd1;
         if (s2_valid && !bus.out_ready && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
      end
   end
`else
   // Counters are absent in the default build.
`endif
endmodule
